// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner: synchronise, debounce and edge-detect one GPIO pad with a sticky irq flag
module gpio_input_conditioner #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pin_async,
  input  logic       enable,
  input  logic [1:0] irq_mode,
  input  logic       irq_clear,
  output logic       pin_clean,
  output logic       rise_pulse,
  output logic       fall_pulse,
  output logic       irq_pending
);
  localparam logic ST_STABLE   = 1'b0;
  localparam logic ST_SETTLING = 1'b1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_pin_clean;
  logic                   r_rise;
  logic                   r_fall;
  logic                   r_irq;
  logic                   w_s;
  logic                   w_differ;
  logic                   w_done;
  logic                   w_next_clean;
  logic                   w_next_state;
  logic [CNT_W-1:0]       w_next_cnt;
  assign w_s = r_sync[SYNC_STAGES-1];
  // A settled level is committed only when the count expires with s still differing
  always_comb begin
    w_differ     = w_s != r_pin_clean;
    w_done       = (r_state == ST_SETTLING) && (r_cnt == LAST);
    w_next_clean = !enable ? w_s : (w_differ && w_done) ? w_s : r_pin_clean;
    w_next_state = (!enable || !w_differ || w_done) ? ST_STABLE : ST_SETTLING;
    w_next_cnt   = (w_next_state == ST_STABLE) ? '0 :
                   (r_state == ST_SETTLING) ? r_cnt + CNT_W'(1) : CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync      <= '0;
      r_state     <= ST_STABLE;
      r_cnt       <= '0;
      r_pin_clean <= 1'b0;
      r_rise      <= 1'b0;
      r_fall      <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], pin_async};
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_pin_clean <= w_next_clean;
      r_rise      <= w_next_clean & ~r_pin_clean;
      r_fall      <= ~w_next_clean & r_pin_clean;
      r_irq       <= (r_rise & irq_mode[0]) | (r_fall & irq_mode[1]) | (r_irq & ~irq_clear);
    end
  end
  assign pin_clean   = r_pin_clean;
  assign rise_pulse  = r_rise;
  assign fall_pulse  = r_fall;
  assign irq_pending = r_irq;
endmodule

// File: tb/tb_gpio_input_conditioner.sv
// tb_gpio_input_conditioner: directed scenarios for the GPIO input conditioner
module tb_gpio_input_conditioner;
  logic       clk = 1'b0;
  logic       reset;
  logic       pin_async;
  logic       enable;
  logic [1:0] irq_mode;
  logic       irq_clear;
  logic       pin_clean;
  logic       rise_pulse;
  logic       fall_pulse;
  logic       irq_pending;
  int checks = 0;
  int errors = 0;

  gpio_input_conditioner dut (
    .clk(clk), .reset(reset), .pin_async(pin_async), .enable(enable),
    .irq_mode(irq_mode), .irq_clear(irq_clear), .pin_clean(pin_clean),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .irq_pending(irq_pending)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; pin_async = 1'b0; enable = 1'b1; irq_mode = 2'b01; irq_clear = 1'b0;
    step(3);
    reset = 1'b0;
    checks++;
    if ({pin_clean, rise_pulse, fall_pulse, irq_pending} !== 4'b0000) begin
      errors++; $display("FAIL reset_outputs got %b exp 0000", {pin_clean, rise_pulse, fall_pulse, irq_pending});
    end
  endtask

  task automatic test_rise_latency;
    pin_async = 1'b1;
    step(17);
    checks++;
    if (pin_clean !== 1'b0) begin errors++; $display("FAIL t1_clean_edge17 got %b exp 0", pin_clean); end
    step(1);
    checks++;
    if (pin_clean !== 1'b1) begin errors++; $display("FAIL t1_clean_edge18 got %b exp 1", pin_clean); end
    checks++;
    if (rise_pulse !== 1'b1) begin errors++; $display("FAIL t1_rise_edge18 got %b exp 1", rise_pulse); end
    checks++;
    if (irq_pending !== 1'b0) begin errors++; $display("FAIL t1_irq_edge18 got %b exp 0", irq_pending); end
    step(1);
    checks++;
    if (rise_pulse !== 1'b0) begin errors++; $display("FAIL t1_rise_edge19 got %b exp 0", rise_pulse); end
    checks++;
    if (irq_pending !== 1'b1) begin errors++; $display("FAIL t1_irq_edge19 got %b exp 1", irq_pending); end
  endtask

  task automatic test_glitch;
    logic bad = 1'b0;
    irq_clear = 1'b1;
    step(1);
    irq_clear = 1'b0;
    checks++;
    if (irq_pending !== 1'b0) begin errors++; $display("FAIL t2_irq_clear got %b exp 0", irq_pending); end
    pin_async = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (i == 10) pin_async = 1'b1;
      step(1);
      if (fall_pulse !== 1'b0 || pin_clean !== 1'b1 || rise_pulse !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL t2_glitch_rejected got %b exp 0", bad); end
    checks++;
    if (dut.r_state !== 1'b0) begin errors++; $display("FAIL t2_state_stable got %b exp 0", dut.r_state); end
  endtask

  task automatic test_bypass;
    logic pa [0:17];
    logic cur, prv;
    for (int i = 0; i < 18; i++) pa[i] = ((i / 3) % 2) == 1;
    enable = 1'b0; irq_mode = 2'b00;
    for (int j = 1; j <= 20; j++) begin
      pin_async = (j - 1 < 18) ? pa[j-1] : 1'b1;
      step(1);
      if (j >= 3) begin
        cur = pa[j-3];
        prv = (j == 3) ? 1'b1 : pa[j-4];
        checks++;
        if (pin_clean !== cur) begin errors++; $display("FAIL t3_clean_e%0d got %b exp %b", j, pin_clean, cur); end
        checks++;
        if (rise_pulse !== (cur & ~prv) || fall_pulse !== (~cur & prv)) begin
          errors++; $display("FAIL t3_pulses_e%0d got r%b f%b exp r%b f%b", j, rise_pulse, fall_pulse, cur & ~prv, ~cur & prv);
        end
      end
    end
    checks++;
    if (irq_pending !== 1'b0) begin errors++; $display("FAIL t3_irq got %b exp 0", irq_pending); end
    enable = 1'b1;
    step(5);
  endtask

  task automatic test_irq_coincide;
    irq_mode = 2'b11;
    pin_async = 1'b0;
    step(18);
    checks++;
    if (fall_pulse !== 1'b1) begin errors++; $display("FAIL t4_fall got %b exp 1", fall_pulse); end
    step(1);
    checks++;
    if (irq_pending !== 1'b1) begin errors++; $display("FAIL t4_irq_fall got %b exp 1", irq_pending); end
    irq_clear = 1'b1;
    step(1);
    irq_clear = 1'b0;
    pin_async = 1'b1;
    step(18);
    checks++;
    if (rise_pulse !== 1'b1) begin errors++; $display("FAIL t4_rise got %b exp 1", rise_pulse); end
    irq_clear = 1'b1;
    step(1);
    checks++;
    if (irq_pending !== 1'b1) begin errors++; $display("FAIL t4_set_wins got %b exp 1", irq_pending); end
    step(1);
    irq_clear = 1'b0;
    checks++;
    if (irq_pending !== 1'b0) begin errors++; $display("FAIL t4_clear_alone got %b exp 0", irq_pending); end
  endtask

  task automatic test_reset_mid;
    pin_async = 1'b0;
    step(20);
    irq_mode = 2'b01;
    pin_async = 1'b1;
    step(10);
    checks++;
    if (dut.r_state !== 1'b1) begin errors++; $display("FAIL t5_settling got %b exp 1", dut.r_state); end
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    checks++;
    if ({pin_clean, rise_pulse, fall_pulse, irq_pending} !== 4'b0000) begin
      errors++; $display("FAIL t5_reset_outputs got %b exp 0000", {pin_clean, rise_pulse, fall_pulse, irq_pending});
    end
    step(17);
    checks++;
    if (pin_clean !== 1'b0 || rise_pulse !== 1'b0) begin
      errors++; $display("FAIL t5_early got c%b r%b exp c0 r0", pin_clean, rise_pulse);
    end
    step(1);
    checks++;
    if (pin_clean !== 1'b1 || rise_pulse !== 1'b1) begin
      errors++; $display("FAIL t5_rise got c%b r%b exp c1 r1", pin_clean, rise_pulse);
    end
    step(1);
    checks++;
    if (irq_pending !== 1'b1) begin errors++; $display("FAIL t5_irq got %b exp 1", irq_pending); end
  endtask

  task automatic test_mode_off;
    int rises = 0;
    int falls = 0;
    irq_clear = 1'b1;
    step(1);
    irq_clear = 1'b0;
    irq_mode = 2'b00;
    for (int k = 0; k < 5; k++) begin
      pin_async = ~pin_async;
      step(18);
      rises += int'(rise_pulse);
      falls += int'(fall_pulse);
      step(2);
      checks++;
      if (irq_pending !== 1'b0) begin errors++; $display("FAIL t6_irq_toggle%0d got %b exp 0", k, irq_pending); end
    end
    checks++;
    if (rises !== 2 || falls !== 3) begin errors++; $display("FAIL t6_pulse_count got r%0d f%0d exp r2 f3", rises, falls); end
  endtask

  task automatic test_enable_toggle;
    int extra = 0;
    pin_async = 1'b1;
    step(8);
    enable = 1'b0;
    step(1);
    checks++;
    if (pin_clean !== 1'b1 || rise_pulse !== 1'b1) begin
      errors++; $display("FAIL t7_bypass_rise got c%b r%b exp c1 r1", pin_clean, rise_pulse);
    end
    enable = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(1);
      extra += int'(rise_pulse) + int'(fall_pulse);
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL t7_no_duplicate got %0d exp 0", extra); end
  endtask

  initial begin
    test_reset;
    test_rise_latency;
    test_glitch;
    test_bypass;
    test_irq_coincide;
    test_reset_mid;
    test_mode_off;
    test_enable_toggle;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
